// File: rtl/bram_pkg.sv
// Shared types and the byte-merge helper for the dual-port scratch RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // merge() works on the widest supported word; callers size-cast in and out.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (mask[i]) result[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Read-output pipeline of 1 or 2 register stages; the payload holds its last
// value whenever no valid word passes through.
module bram_out_pipe
  import bram_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  assign s1_data_d = valid_i ? data_i : s1_data_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= valid_i;
      s1_data_q  <= s1_data_d;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    assign s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_data_q  <= s2_data_d;
      end
    end

    assign valid_o = s2_valid_q;
    assign data_o  = s2_data_q;
  end else begin : g_lat1
    assign valid_o = s1_valid_q;
    assign data_o  = s1_data_q;
  end

endmodule

// File: rtl/bram_dp.sv
// Dual-port scratch RAM: port A read/write with byte enables, port B read-only,
// zeroed by a clear sweep after every reset before requests are accepted.
module bram_dp
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  input  logic                    a_en,
  input  logic                    a_write_en,
  input  logic [DATA_WIDTH/8-1:0] a_byte_en,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  output logic                    b_valid,
  output logic                    collision
);

  localparam int                    NBYTES    = DATA_WIDTH / 8;
  localparam write_mode_e           WMODE     = write_mode_e'(WRITE_MODE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    case (state_q)
      CLEAR: begin
        clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
        if (clear_cnt_q == LAST_ADDR) begin
          state_d     = READY;
          clear_cnt_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign init_done = (state_q == READY);

  logic                  a_acc, a_wr, a_in_range, b_acc, b_in_range, b_hit;
  logic [DATA_WIDTH-1:0] a_old, a_merged, b_old;
  logic                  a_pipe_valid;
  logic [DATA_WIDTH-1:0] a_pipe_data;

  assign a_acc      = a_en & init_done;
  assign a_wr       = a_acc & a_write_en;
  assign b_acc      = b_en & init_done;
  assign a_in_range = {1'b0, a_address} < DEPTH_EXT;
  assign b_in_range = {1'b0, b_address} < DEPTH_EXT;

  // Both reads see the pre-write word, which gives read-before-write on a collision.
  assign a_old    = a_in_range ? mem[a_address] : '0;
  assign b_old    = b_in_range ? mem[b_address] : '0;
  assign a_merged = a_in_range ? DATA_WIDTH'(merge(MAX_DATA_WIDTH'(a_old),
                                                   MAX_DATA_WIDTH'(a_data_in),
                                                   MAX_BYTES'(a_byte_en)))
                               : '0;

  assign a_pipe_valid = a_acc & (~a_write_en | (WMODE != NO_CHANGE));
  assign a_pipe_data  = (a_write_en && (WMODE == WRITE_FIRST)) ? a_merged : a_old;
  assign b_hit        = a_wr & b_acc & (a_address == b_address);

  // NOTE: the array has no reset; the clear sweep zeroes it after each reset instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clear_cnt_q] <= '0;
    end else if (a_wr && a_in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (a_byte_en[i]) mem[a_address][i*8 +: 8] <= a_data_in[i*8 +: 8];
      end
    end
  end

  bram_out_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH)
  ) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (a_pipe_valid),
    .data_i  (a_pipe_data),
    .valid_o (a_valid),
    .data_o  (a_data_out)
  );

  // Port B carries the collision bit alongside its data word.
  logic [DATA_WIDTH:0] b_pipe_out;
  logic                b_flag;

  bram_out_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH + 1)
  ) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (b_acc),
    .data_i  ({b_hit, b_old}),
    .valid_o (b_valid),
    .data_o  (b_pipe_out)
  );

  assign b_flag     = b_pipe_out[DATA_WIDTH];
  assign b_data_out = b_pipe_out[DATA_WIDTH-1:0];
  assign collision  = b_valid & b_flag;

endmodule

// File: doc/bram_dp.md
Name: bram_dp

Overview:
- Parametrised successor to the single-port 8-bit bram.
- Port A is read/write with byte enables. Port B is read-only.
- Read latency is selectable (1 or 2). Port A write-mode is selectable.
- A post-reset clear engine zeroes the array. Sits between datapath producers/consumers as a scratch buffer (e.g. the rectangle-loop line/tile store).

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted request to data (legal: 1 or 2).
- WRITE_MODE, 0, port A data_out on a write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the clear sweep has completed; ports are accepted only when high.
- a_en  in  1  port A request.
- a_write_en  in  1  port A write (when a_en=1).
- a_byte_en  in  DATA_WIDTH/8  per-byte write mask.
- a_address  in  ADDR_WIDTH  port A address.
- a_data_in  in  DATA_WIDTH  port A write data.
- a_data_out  out  DATA_WIDTH  port A read data.
- a_valid  out  1  pulses with valid a_data_out.
- b_en  in  1  port B read request.
- b_address  in  ADDR_WIDTH  port B address.
- b_data_out  out  DATA_WIDTH  port B read data.
- b_valid  out  1  pulses with valid b_data_out.
- collision  out  1  registered flag: A-write and B-read hit the same address in the same cycle.

Behaviour:
- Reset (async assert, any time, including mid-clear): state=CLEAR, clear counter=0.
  - init_done=0, a_valid=0, b_valid=0, collision=0, a_data_out=0, b_data_out=0.
  - All pipeline valid bits cleared. Memory contents are not reset asynchronously.
- FSM CLEAR: writes 0 to word clear_cnt each cycle; clear_cnt increments.
  - When clear_cnt==DEPTH-1 is written, next state is READY and init_done=1 the following cycle.
  - Total DEPTH cycles after rst deasserts. Requests during CLEAR are ignored (no valid produced).
- FSM READY: stays READY until rst.
- Request acceptance: a request is accepted when en=1 and init_done=1. Address ≥ DEPTH: write dropped, read returns 0; valid still pulses.
- Port A write: byte i of mem[a_address] is updated iff a_byte_en[i]. a_byte_en=0 performs no update but still follows the WRITE_MODE output rule.
- Port A output on write:
  - READ_FIRST: old word, a_valid pulses.
  - WRITE_FIRST: merged new word, a_valid pulses.
  - NO_CHANGE: a_data_out holds its previous value and a_valid stays 0.
- Port A read (a_write_en=0): word returned, a_valid pulses.
- Latency:
  - READ_LATENCY=1: data/valid register on the edge after acceptance.
  - READ_LATENCY=2: an extra output register; data/valid appear one cycle later.
  - Back-to-back requests are accepted every cycle; throughput is 1/cycle per port.
- Data outputs hold their last value when valid=0.
- Collision (A write and B read on the same address, same cycle): B always returns the old word (read-before-write). collision=1 for exactly one cycle, aligned with b_valid.
- Port B never writes. Two reads on the same address are not a collision.

Decomposition:
- Package bram_pkg: write_mode_e enum (READ_FIRST, WRITE_FIRST, NO_CHANGE), state_e (CLEAR, READY), and a byte-merge function merge(old, new, mask).
- One sub-module: bram_out_pipe, parametrised by latency, which carries data+valid (and collision for port B). It is instantiated once per port.

Test Plan:
- Clear sweep: deassert rst; init_done rises after exactly 256 cycles. Port-A read of every address returns 0x00000000 with a_valid one cycle after each request.
- Byte write: write 0xAABBCCDD to addr 5 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101. A read of addr 5 returns 0xAA22CC44.
- Write modes: with addr 7 holding 0x12345678, write 0xCAFEF00D.
  - READ_FIRST: a_data_out=0x12345678.
  - WRITE_FIRST: a_data_out=0xCAFEF00D.
  - NO_CHANGE: a_valid stays 0 and a_data_out is unchanged.
- Collision: with addr 2 holding 0x68, A writes 0x69 to addr 2 while B reads addr 2. b_data_out=0x68 and collision=1 for one cycle; the next B read of addr 2 returns 0x69.
- READ_LATENCY=2 streaming: B reads addrs 0..3 on consecutive cycles. b_valid is high for 4 consecutive cycles starting 2 cycles after the first request, with data in order.
- Reset mid-clear: assert rst at clear_cnt=100. All outputs go to 0 immediately, and init_done rises a full 256 cycles after the release.
